// File: rtl/mem_pkg.sv
// Shared constants for the data-memory controller: funct3 encodings, FSM states,
// default bus timeout and the store-side lane helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic access_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] off);
        logic f3_ok;
        logic align_ok;
        f3_ok    = rd ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                      : (f3 inside {F3_B, F3_H, F3_W});
        align_ok = 1'b1;
        if ((f3 == F3_H || f3 == F3_HU) && off[0]) align_ok = 1'b0;
        if (f3 == F3_W && off != 2'b00)            align_ok = 1'b0;
        return (rd ^ wr) && f3_ok && align_ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Memory-side bus of the data-memory controller: request/ack handshake plus
// word address, byte lanes and data in both directions.
interface data_mem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    input  bus_ack, bus_rdata);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    output bus_ack, bus_rdata);
endinterface

// File: rtl/load_aligner.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s = word[{offset, 3'b000} +: 8];
        half_s = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_s[7]}}, byte_s};
            F3_BU:   result = {24'h0, byte_s};
            F3_H:    result = {{16{half_s[15]}}, half_s};
            F3_HU:   result = {16'h0, half_s};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit front end: checks the access, runs one bus transaction with a
// bounded wait, and returns the aligned load result for one DONE cycle.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            stall,
    output logic            access_fault,
    data_mem_ctrl_if.master bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [31:0]         rdata_q;
    logic                fault_q;
    logic                req_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;

    logic                legal_d;
    logic [31:0]         load_d;

    assign legal_d = access_legal(mem_read, mem_write, funct3, addr[1:0]);

    load_aligner u_align (
        .word   (bus.bus_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        if (legal_d) begin
                            state_q <= BUSY;
                            wait_q  <= '0;
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= mem_write ? store_be(funct3, addr[1:0]) : 4'b1111;
                            wdata_q <= store_data(funct3, wdata);
                            f3_q    <= funct3;
                            off_q   <= addr[1:0];
                        end else begin
                            state_q <= DONE;
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                // An ack in the final wait cycle still completes normally.
                BUSY: begin
                    if (bus.bus_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        if (!we_q) rdata_q <= load_d;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall         = ((state_q == IDLE) && (mem_read || mem_write)) || (state_q == BUSY);
    assign rdata         = rdata_q;
    assign access_fault  = fault_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for bus_ack before faulting.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 mem_read  in  1  load requested this cycle, driven by the decoder.
REQ-006 mem_write  in  1  store requested this cycle, driven by the decoder.
REQ-007 funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  in  32  byte address from the ALU.
REQ-009 wdata  in  32  store data from rs2.
REQ-010 rdata  out  32  aligned and extended load result, valid in DONE.
REQ-011 stall  out  1  holds the CPU while the access is in flight.
REQ-012 access_fault  out  1  one-cycle pulse on a misaligned, illegal, or timed-out access.
REQ-013 bus_req  out  1  bus request, held until acknowledged.
REQ-014 bus_we  out  1  1 = write.
REQ-015 bus_addr  out  32  word address, with bits [1:0] = 00.
REQ-016 bus_be  out  4  byte-lane enables.
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_ack  in  1  one-cycle completion strobe from the memory.
REQ-019 bus_rdata  in  32  read word, valid when bus_ack = 1.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-021 IDLE SHALL move to BUSY only on a legal access (exactly one of mem_read/mem_write, legal funct3, aligned address); on that edge it SHALL register bus_addr, bus_we, bus_be, bus_wdata, funct3 and addr[1:0].
REQ-022 An illegal access in IDLE SHALL go to DONE, pulse access_fault, issue no bus transaction, and set rdata = 0.
REQ-023 The following SHALL be illegal:
- both mem_read and mem_write set;
- a load funct3 outside 000/001/010/100/101;
- a store funct3 outside 000/001/010;
- H/HU with addr[0] = 1;
- W with addr[1:0] != 00.
REQ-024 stall SHALL be combinational: 1 in IDLE when mem_read or mem_write is set, 1 in BUSY, 0 in DONE.
REQ-025 bus_req SHALL be 1 throughout BUSY and SHALL stay stable, with all bus outputs held, until bus_ack is sampled.
REQ-026 On bus_ack in BUSY, the block SHALL go to DONE; for loads it SHALL register the extracted rdata on that edge.
REQ-027 Minimum latency SHALL be request at cycle 0, bus_req at cycles 1 to n, DONE at cycle n+1; with a zero-wait ack at cycle 1, stall drops at cycle 2.
REQ-028 A wait counter SHALL clear on entering BUSY and increment each BUSY cycle without bus_ack.
REQ-029 When the wait counter reaches TIMEOUT, the block SHALL drop bus_req, go to DONE, pulse access_fault, and set rdata = 0; a bus_ack in that same cycle SHALL win over the timeout.
REQ-030 DONE SHALL last exactly one cycle, ignore all inputs, and return to IDLE.
REQ-031 Store byte enables SHALL be:
- SB: be = 0001 << addr[1:0], with the byte replicated ×4;
- SH: be = 0011 << (2·addr[1]), with the half replicated ×2;
- SW: be = 1111.
REQ-032 Loads SHALL select the lane by the registered addr[1:0]; B/H SHALL sign-extend from bit 7/15; BU/HU SHALL zero-extend.
REQ-033 A bus_ack outside BUSY SHALL be ignored.
REQ-034 rdata SHALL hold its value outside DONE; stores SHALL not change rdata.

Reset
REQ-035 Asserting rst_n low SHALL immediately set: state IDLE, wait counter 0, rdata 0, access_fault 0, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0.
REQ-036 A reset during BUSY SHALL abandon the transaction (bus_req falls asynchronously); a late bus_ack after reset release SHALL be ignored.

Structure
REQ-037 A shared package mem_pkg SHALL hold the funct3 constants, the state encoding and the default TIMEOUT.
REQ-038 Load lane selection and extension SHALL be one combinational sub-module, load_aligner (inputs word, offset, funct3; output 32-bit result).

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- LB, addr 0x103, bus_rdata 0x80FF_1234, ack at cycle 1 -> bus_addr 0x100, bus_be 1111 ignored for read, rdata 0xFFFF_FF80, stall high for 2 cycles.
- SH, addr 0x202, wdata 0x0000_ABCD -> bus_be 1100, bus_wdata 0xABCD_ABCD, bus_we 1, bus_addr 0x200.
- LW, addr 0x006 -> access_fault pulse, no bus_req, rdata 0, DONE then IDLE.
- LHU, addr 0x10, ack withheld -> bus_req high for 16 cycles, then access_fault, rdata 0; ack arriving on cycle 16 -> normal completion, no fault.
- mem_read and mem_write both 1 -> fault, no bus_req.
- rst_n low at BUSY cycle 3 -> bus_req 0 immediately; ack after release -> no state change, rdata stays 0.
